// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register map, STATUS layout,
// generic I/O request bundle and transmitter state encoding.
package mmio_uart_tx_pkg;

    localparam logic [7:0] UART_TXDATA_OFS = 8'h00;
    localparam logic [7:0] UART_STATUS_OFS = 8'h04;
    localparam logic [7:0] UART_BAUD_OFS   = 8'h08;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 9;

    typedef struct packed {
        logic        cs;
        logic        rd_en;
        logic        wr_en;
        logic [7:0]  addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_strobe;
    } io_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_e;

    // A divisor of zero behaves as one so the bit timer can never stall.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push is refused when the
// registered count says full, regardless of a same-cycle pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV registers on the
// I/O bus, a byte FIFO, and a bit-timing FSM driving a registered serial line.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH       = 16,
    parameter int DEFAULT_BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_cs,
    input  logic        io_rd_en,
    input  logic        io_wr_en,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_wr_data,
    input  logic [3:0]  io_wr_strobe,
    output logic [31:0] io_rd_data,
    output logic        io_rd_valid,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    io_req_t        req;
    logic           wr, rd, sel_tx, sel_stat, sel_baud;
    logic           push, pop, full, empty;
    logic [7:0]     fifo_head;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status_w;
    logic [15:0]    div_m1;
    logic           unused_req;

    uart_tx_state_e state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;

    assign req = '{cs: io_cs, rd_en: io_rd_en, wr_en: io_wr_en, addr: io_addr,
                   wr_data: io_wr_data, wr_strobe: io_wr_strobe};
    assign unused_req = ^{req.addr[1:0], req.wr_data[31:16], req.wr_strobe[3:2]};

    assign wr       = req.cs && req.wr_en;
    assign rd       = req.cs && req.rd_en;
    assign sel_tx   = (req.addr[7:2] == UART_TXDATA_OFS[7:2]);
    assign sel_stat = (req.addr[7:2] == UART_STATUS_OFS[7:2]);
    assign sel_baud = (req.addr[7:2] == UART_BAUD_OFS[7:2]);
    assign push     = wr && sel_tx && req.wr_strobe[0];
    assign div_m1   = eff_div(baud_q) - 16'd1;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (req.wr_data[7:0]),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        status_w                                 = '0;
        status_w[STAT_BUSY]                      = (state_q != ST_IDLE);
        status_w[STAT_FULL]                      = full;
        status_w[STAT_EMPTY]                     = empty;
        status_w[STAT_OVF]                       = ovf_q;
        status_w[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);

        baud_d = baud_q;
        if (wr && sel_baud) begin
            if (req.wr_strobe[0]) baud_d[7:0]  = req.wr_data[7:0];
            if (req.wr_strobe[1]) baud_d[15:8] = req.wr_data[15:8];
        end

        // Set has priority over the W1C clear in the same cycle.
        ovf_d = ovf_q;
        if (wr && sel_stat && req.wr_strobe[0] && req.wr_data[STAT_OVF]) ovf_d = 1'b0;
        if (push && full) ovf_d = 1'b1;

        rd_valid_d = rd;
        rd_data_d  = '0;
        if (rd) begin
            if (sel_stat)      rd_data_d = status_w;
            else if (sel_baud) rd_data_d = {16'h0000, baud_q};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                shift_d = fifo_head;
                cnt_d   = div_m1;
                state_d = ST_START;
                tx_d    = 1'b0;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            // Bit boundary: a new divisor only takes effect from here on.
            cnt_d = div_m1;
            if (state_q == ST_START) begin
                state_d = ST_DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end else if (state_q == ST_DATA) begin
                if (bit_q == 3'd7) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[1];
                end
            end else begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= 16'(DEFAULT_BAUD_DIV);
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign uart_tx     = tx_q;
    assign io_rd_data  = rd_data_q;
    assign io_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected read data and serial bytes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_cs, io_rd_en, io_wr_en;
    logic [7:0]  io_addr;
    logic [31:0] io_wr_data;
    logic [3:0]  io_wr_strobe;
    logic [31:0] io_rd_data;
    logic        io_rd_valid;
    logic        uart_tx;

    always #5 clk = ~clk;

    mmio_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_BAUD_DIV(434)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_cs        (io_cs),
        .io_rd_en     (io_rd_en),
        .io_wr_en     (io_wr_en),
        .io_addr      (io_addr),
        .io_wr_data   (io_wr_data),
        .io_wr_strobe (io_wr_strobe),
        .io_rd_data   (io_rd_data),
        .io_rd_valid  (io_rd_valid),
        .uart_tx      (uart_tx)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    rd_exp_t    rd_e;
    logic [7:0] tx_q[$];
    int         starts[$];
    int         frames_seen = 0;
    int         frames_exp = 0;
    int         mon_div = 434;
    bit         mon_ignore = 1'b0;

    // Read response monitor: one-cycle latency, zero data when not valid.
    always @(negedge clk) begin
        if (io_rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("rd_spurious", 32'(io_rd_valid), 32'd0);
            end else begin
                rd_e = rd_q.pop_front();
                chk("rd_latency", cyc, rd_e.due);
                chk("rd_data", io_rd_data, rd_e.data);
            end
        end else if (io_rd_data !== 32'd0) begin
            chk("rd_idle_zero", io_rd_data, 32'd0);
        end
    end

    // Serial monitor: mid-bit sampling at the divisor in force when the frame starts.
    int         m_d;
    logic [7:0] m_b;
    logic       m_start, m_stop;
    logic [7:0] m_exp;
    always begin
        @(negedge clk);
        if (rst === 1'b0 && uart_tx === 1'b0) begin
            m_d = mon_div;
            starts.push_back(cyc);
            repeat (m_d / 2) @(negedge clk);
            m_start = uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (m_d) @(negedge clk);
                m_b[i] = uart_tx;
            end
            repeat (m_d) @(negedge clk);
            m_stop = uart_tx;
            if (!mon_ignore) begin
                frames_seen++;
                if (tx_q.size() > 0) begin
                    m_exp = tx_q.pop_front();
                    chk("tx_byte", 32'(m_b), 32'(m_exp));
                    chk("tx_start_bit", 32'(m_start), 32'd0);
                    chk("tx_stop_bit", 32'(m_stop), 32'd1);
                end
            end
        end
    end

    task automatic bus(input logic cs, input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [31:0] exp);
        rd_exp_t e;
        @(negedge clk);
        io_cs        = cs;
        io_rd_en     = rd;
        io_wr_en     = wr;
        io_addr      = addr;
        io_wr_data   = data;
        io_wr_strobe = strb;
        if (cs && rd) begin
            e.data = exp;
            e.due  = cyc + 1;
            rd_q.push_back(e);
        end
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus(1'b1, 1'b0, 1'b1, addr, data, strb, 32'd0);
    endtask

    task automatic bus_rd(input logic [7:0] addr, input logic [31:0] exp);
        bus(1'b1, 1'b1, 1'b0, addr, 32'd0, 4'd0, exp);
    endtask

    task automatic bus_idle();
        bus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_wr(UART_TXDATA_OFS, {24'd0, b}, 4'b0001);
        tx_q.push_back(b);
        frames_exp++;
    endtask

    task automatic set_baud(input int d);
        bus_wr(UART_BAUD_OFS, 32'(d), 4'b0011);
        mon_div = d;
        bus_idle();
    endtask

    task automatic wait_tx_drain(input int max_cyc);
        int n = 0;
        while (tx_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain", 32'(tx_q.size()), 32'd0);
        repeat (mon_div + 5) @(negedge clk);
    endtask

    // Expected line level k cycles after the byte was written, for divisor d.
    function automatic logic exp_line(input int k, input int d, input logic [7:0] b);
        int bi;
        if (k < 1 || k > 10 * d) return 1'b1;
        bi = (k - 1) / d;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        return 1'b1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c0;
        int          s0;
        int          zeros;
        logic [31:0] st_exp;
        logic [7:0]  a5;

        rst = 1'b1;
        io_cs = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0;
        io_addr = 8'h00; io_wr_data = 32'd0; io_wr_strobe = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_rd_valid", 32'(io_rd_valid), 32'd0);
        chk("rst_rd_data", io_rd_data, 32'd0);

        bus_rd(UART_STATUS_OFS, 32'h0000_0004);
        bus_rd(UART_BAUD_OFS, 32'd434);
        bus_rd(UART_TXDATA_OFS, 32'd0);
        bus_rd(8'h0C, 32'd0);
        bus_idle();

        // Upper byte lane only: 0x01B2 becomes 0x05B2.
        bus_wr(UART_BAUD_OFS, 32'h0000_0500, 4'b0010);
        bus_rd(UART_BAUD_OFS, 32'h0000_05B2);
        bus_idle();

        // Single 0xA5 frame at divisor 4, line and busy checked every cycle.
        set_baud(4);
        a5 = 8'hA5;
        send_byte(a5);
        c0 = cyc;
        for (int k = 0; k < 46; k++) begin
            if (k == 0)       st_exp = 32'h0000_0100;
            else if (k <= 40) st_exp = 32'h0000_0005;
            else              st_exp = 32'h0000_0004;
            bus_rd(UART_STATUS_OFS, st_exp);
            chk("a5_line", 32'(uart_tx), 32'(exp_line(cyc - c0 - 1, 4, a5)));
        end
        bus_idle();
        wait_tx_drain(200);

        // Back-to-back frames at divisor 2: one idle cycle between them.
        set_baud(2);
        s0 = starts.size();
        send_byte(8'h01);
        send_byte(8'h02);
        bus_idle();
        bus_rd(UART_STATUS_OFS, 32'h0000_0101);
        bus_idle();
        wait_tx_drain(300);
        if (starts.size() >= s0 + 2) chk("b2b_gap", starts[s0+1] - starts[s0], 32'd21);
        else chk("b2b_frames", 32'(starts.size()), 32'(s0 + 2));

        // Overflow: one byte goes straight to the shifter, sixteen fill the
        // FIFO, and the eighteenth write finds it full and is dropped.
        set_baud(20);
        for (int i = 0; i < 18; i++) begin
            if (i < 17) send_byte(8'h30 + 8'(i));
            else bus_wr(UART_TXDATA_OFS, 32'h0000_00EE, 4'b0001);
        end
        bus_rd(UART_STATUS_OFS, 32'h0000_100B);
        bus(1'b0, 1'b1, 1'b1, UART_STATUS_OFS, 32'h8, 4'b0001, 32'd0);
        bus(1'b0, 1'b1, 1'b1, UART_BAUD_OFS, 32'h3, 4'b0011, 32'd0);
        bus(1'b0, 1'b0, 1'b1, UART_TXDATA_OFS, 32'h77, 4'b1111, 32'd0);
        bus_rd(UART_STATUS_OFS, 32'h0000_100B);
        bus_rd(UART_BAUD_OFS, 32'd20);
        bus(1'b1, 1'b1, 1'b1, UART_STATUS_OFS, 32'h8, 4'b0001, 32'h0000_100B);
        bus_rd(UART_STATUS_OFS, 32'h0000_1003);
        bus_idle();
        wait_tx_drain(4000);

        // Reset while data bit 3 of an all-zero byte is on the line.
        set_baud(4);
        mon_ignore = 1'b1;
        bus_wr(UART_TXDATA_OFS, 32'h0000_0000, 4'b0001);
        bus_idle();
        repeat (17) @(negedge clk);
        chk("pre_rst_line", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mon_div = 434;
        chk("mid_rst_line", 32'(uart_tx), 32'd1);
        bus_rd(UART_STATUS_OFS, 32'h0000_0004);
        bus_rd(UART_BAUD_OFS, 32'd434);
        bus_idle();
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) zeros++;
        end
        chk("no_partial_frame", 32'(zeros), 32'd0);
        mon_ignore = 1'b0;

        repeat (5) @(negedge clk);
        chk("frames_total", 32'(frames_seen), 32'(frames_exp));
        chk("rd_pending", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
